// File: rtl/mem_arb2.sv
// Two-master arbiter ahead of the memory controller command port.
// Master 0 (video DMA) has fixed priority. Master 1 gets a grant after at most
// MAX_M0 consecutive master-0 grants made while it waits. Only one transaction
// is in flight at a time. Data paths are pure combinational muxes and gates.
module mem_arb2 #(
  parameter int MAX_M0 = 4
) (
  input  logic        clk,
  input  logic        rst,
  // master 0
  input  logic [31:0] m0_addr,
  input  logic [6:0]  m0_len,
  input  logic        m0_rw,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_wdata,
  output logic        m0_wack,
  output logic        m0_wlast,
  output logic [31:0] m0_rdata,
  output logic        m0_rstb,
  output logic        m0_rlast,
  // master 1
  input  logic [31:0] m1_addr,
  input  logic [6:0]  m1_len,
  input  logic        m1_rw,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_wdata,
  output logic        m1_wack,
  output logic        m1_wlast,
  output logic [31:0] m1_rdata,
  output logic        m1_rstb,
  output logic        m1_rlast,
  // controller
  output logic [31:0] s_addr,
  output logic [6:0]  s_len,
  output logic        s_rw,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_wdata,
  input  logic        s_wack,
  input  logic        s_wlast,
  input  logic [31:0] s_rdata,
  input  logic        s_rstb,
  input  logic        s_rlast
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [31:0] MAX_M0_U = MAX_M0;

  state_t      state_p0;
  logic        owner_p0;
  logic [7:0]  streak_p0;
  logic        rw_p0;

  logic        in_cmd;
  logic        in_data;
  logic        own_valid;
  logic        handshake;
  logic        streak_hit;
  logic        grant_m1;
  logic        data_done;

  // Streak counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_cmd    = (state_p0 == CMD);
  assign in_data   = (state_p0 == DATA);
  assign own_valid = owner_p0 ? m1_valid : m0_valid;

  // A zero MAX_M0 disables the starvation limit entirely.
  assign streak_hit = (MAX_M0_U != 32'd0) && (32'(streak_p0) >= MAX_M0_U);
  assign grant_m1   = m1_valid && (!m0_valid || streak_hit);

  // Command path: owner's fields always presented; valid only while in CMD.
  assign s_addr    = owner_p0 ? m1_addr  : m0_addr;
  assign s_len     = owner_p0 ? m1_len   : m0_len;
  assign s_rw      = owner_p0 ? m1_rw    : m0_rw;
  assign s_wdata   = owner_p0 ? m1_wdata : m0_wdata;
  assign s_valid   = in_cmd & own_valid;
  assign handshake = s_valid & s_ready;

  assign m0_ready  = handshake & ~owner_p0;
  assign m1_ready  = handshake &  owner_p0;

  // Return strobes reach only the owner and only during the data phase.
  assign m0_wack   = in_data & ~owner_p0 & s_wack;
  assign m0_wlast  = in_data & ~owner_p0 & s_wlast;
  assign m0_rstb   = in_data & ~owner_p0 & s_rstb;
  assign m0_rlast  = in_data & ~owner_p0 & s_rlast;
  assign m1_wack   = in_data &  owner_p0 & s_wack;
  assign m1_wlast  = in_data &  owner_p0 & s_wlast;
  assign m1_rstb   = in_data &  owner_p0 & s_rstb;
  assign m1_rlast  = in_data &  owner_p0 & s_rlast;

  // Read data is broadcast; the gated strobes qualify it.
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  // End of burst judged by the direction latched at command acceptance.
  assign data_done = in_data & (rw_p0 ? (s_rstb & s_rlast) : (s_wack & s_wlast));

  // Arbitration FSM: grant in IDLE, hand the command over in CMD, track the burst in DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= IDLE;
      owner_p0  <= 1'b0;
      streak_p0 <= 8'd0;
      rw_p0     <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (grant_m1) begin
            owner_p0  <= 1'b1;
            streak_p0 <= 8'd0;
            state_p0  <= CMD;
          end else if (m0_valid) begin
            owner_p0  <= 1'b0;
            streak_p0 <= m1_valid ? sat_inc(streak_p0) : 8'd0;
            state_p0  <= CMD;
          end
        end
        CMD: begin
          if (handshake) begin
            rw_p0    <= s_rw;
            state_p0 <= DATA;
          end else if (!own_valid) begin
            // Owner withdrew its request before acceptance: nothing was issued.
            state_p0 <= IDLE;
          end
        end
        DATA: begin
          if (data_done) begin
            state_p0 <= IDLE;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2: one task per scenario, called in order.
// A second instance with MAX_M0=0 runs against a controller that always accepts
// and immediately ends every burst, to observe strict-priority grant order.
module tb_mem_arb2;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] m0_addr, m1_addr;
  logic [6:0]  m0_len, m1_len;
  logic        m0_rw, m1_rw, m0_valid, m1_valid;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready;
  logic        m0_wack, m0_wlast, m0_rstb, m0_rlast;
  logic        m1_wack, m1_wlast, m1_rstb, m1_rlast;
  logic [31:0] m0_rdata, m1_rdata;

  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [6:0]  s_len;
  logic        s_rw, s_valid, s_ready;
  logic        s_wack, s_wlast, s_rstb, s_rlast;

  // strict-priority instance outputs
  logic        d0_m0_ready, d0_m1_ready;
  logic        d0_m0_wack, d0_m0_wlast, d0_m0_rstb, d0_m0_rlast;
  logic        d0_m1_wack, d0_m1_wlast, d0_m1_rstb, d0_m1_rlast;
  logic [31:0] d0_m0_rdata, d0_m1_rdata, d0_s_addr, d0_s_wdata;
  logic [6:0]  d0_s_len;
  logic        d0_s_rw, d0_s_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arb2 #(.MAX_M0(4)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_len(m0_len), .m0_rw(m0_rw), .m0_valid(m0_valid),
    .m0_ready(m0_ready), .m0_wdata(m0_wdata), .m0_wack(m0_wack), .m0_wlast(m0_wlast),
    .m0_rdata(m0_rdata), .m0_rstb(m0_rstb), .m0_rlast(m0_rlast),
    .m1_addr(m1_addr), .m1_len(m1_len), .m1_rw(m1_rw), .m1_valid(m1_valid),
    .m1_ready(m1_ready), .m1_wdata(m1_wdata), .m1_wack(m1_wack), .m1_wlast(m1_wlast),
    .m1_rdata(m1_rdata), .m1_rstb(m1_rstb), .m1_rlast(m1_rlast),
    .s_addr(s_addr), .s_len(s_len), .s_rw(s_rw), .s_valid(s_valid), .s_ready(s_ready),
    .s_wdata(s_wdata), .s_wack(s_wack), .s_wlast(s_wlast), .s_rdata(s_rdata),
    .s_rstb(s_rstb), .s_rlast(s_rlast)
  );

  mem_arb2 #(.MAX_M0(0)) dut0 (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_len(m0_len), .m0_rw(m0_rw), .m0_valid(m0_valid),
    .m0_ready(d0_m0_ready), .m0_wdata(m0_wdata), .m0_wack(d0_m0_wack), .m0_wlast(d0_m0_wlast),
    .m0_rdata(d0_m0_rdata), .m0_rstb(d0_m0_rstb), .m0_rlast(d0_m0_rlast),
    .m1_addr(m1_addr), .m1_len(m1_len), .m1_rw(m1_rw), .m1_valid(m1_valid),
    .m1_ready(d0_m1_ready), .m1_wdata(m1_wdata), .m1_wack(d0_m1_wack), .m1_wlast(d0_m1_wlast),
    .m1_rdata(d0_m1_rdata), .m1_rstb(d0_m1_rstb), .m1_rlast(d0_m1_rlast),
    .s_addr(d0_s_addr), .s_len(d0_s_len), .s_rw(d0_s_rw), .s_valid(d0_s_valid), .s_ready(1'b1),
    .s_wdata(d0_s_wdata), .s_wack(1'b1), .s_wlast(1'b1), .s_rdata(32'd0),
    .s_rstb(1'b1), .s_rlast(1'b1)
  );

  task automatic clear_inputs;
    m0_addr = '0; m0_len = '0; m0_rw = 1'b0; m0_valid = 1'b0; m0_wdata = '0;
    m1_addr = '0; m1_len = '0; m1_rw = 1'b0; m1_valid = 1'b0; m1_wdata = '0;
    s_ready = 1'b0; s_wack = 1'b0; s_wlast = 1'b0; s_rdata = '0; s_rstb = 1'b0; s_rlast = 1'b0;
  endtask

  task automatic ctrl_all_high;
    s_ready = 1'b1; s_wack = 1'b1; s_wlast = 1'b1; s_rstb = 1'b1; s_rlast = 1'b1;
  endtask

  task automatic test_reset;
    logic [10:0] outs;
    clear_inputs();
    rst = 1'b1;
    ctrl_all_high();
    repeat (2) @(negedge clk);
    #1;
    outs = {s_valid, m0_ready, m1_ready, m0_wack, m0_wlast, m0_rstb, m0_rlast,
            m1_wack, m1_wlast, m1_rstb, m1_rlast};
    checks++;
    if (outs !== 11'd0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", outs, 11'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_single_read;
    logic [31:0] d;
    @(negedge clk);
    m0_addr = 32'h100; m0_len = 7'd3; m0_rw = 1'b1; m0_valid = 1'b1; s_ready = 1'b1;
    #1;
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL rd_idle_svalid: got %b expected 0", s_valid); end
    @(negedge clk); #1;
    checks++;
    if ({s_valid, s_addr, s_len, s_rw} !== {1'b1, 32'h100, 7'd3, 1'b1}) begin
      errors++; $display("FAIL rd_cmd: got v=%b a=%h l=%0d rw=%b expected v=1 a=100 l=3 rw=1", s_valid, s_addr, s_len, s_rw);
    end
    checks++;
    if ({m0_ready, m1_ready} !== 2'b10) begin
      errors++; $display("FAIL rd_ready: got %b expected 10", {m0_ready, m1_ready});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_valid = 1'b0; s_ready = 1'b0;
      d = 32'hC0DE0000 + i;
      s_rstb = 1'b1; s_rdata = d; s_rlast = (i == 3);
      #1;
      checks++;
      if ({s_valid, m0_rstb, m1_rstb, m0_rlast, m0_rdata} !== {1'b0, 1'b1, 1'b0, (i == 3), d}) begin
        errors++; $display("FAIL rd_beat%0d: got v=%b s0=%b s1=%b l0=%b d=%h expected v=0 s0=1 s1=0 l0=%b d=%h",
                           i, s_valid, m0_rstb, m1_rstb, m0_rlast, m0_rdata, (i == 3), d);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({m0_rstb, m0_rlast, s_valid} !== 3'b000) begin
      errors++; $display("FAIL rd_back_idle: got %b expected 000", {m0_rstb, m0_rlast, s_valid});
    end
    clear_inputs();
  endtask

  task automatic test_write_m1;
    logic [31:0] w;
    @(negedge clk);
    m1_addr = 32'h2000; m1_len = 7'd7; m1_rw = 1'b0; m1_valid = 1'b1; m1_wdata = 32'hA5A50000;
    s_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({s_valid, s_addr, s_len, s_rw, m1_ready, m0_ready} !== {1'b1, 32'h2000, 7'd7, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wr_cmd: got v=%b a=%h l=%0d rw=%b r1=%b r0=%b expected v=1 a=2000 l=7 rw=0 r1=1 r0=0",
                         s_valid, s_addr, s_len, s_rw, m1_ready, m0_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m1_valid = 1'b0; s_ready = 1'b0;
      w = 32'hA5A50000 + i;
      m1_wdata = w; s_wack = 1'b1; s_wlast = (i == 7);
      #1;
      checks++;
      if ({s_wdata, m1_wack, m1_wlast, m0_wack, m0_wlast} !== {w, 1'b1, (i == 7), 1'b0, 1'b0}) begin
        errors++; $display("FAIL wr_beat%0d: got wd=%h a1=%b l1=%b a0=%b l0=%b expected wd=%h a1=1 l1=%b a0=0 l0=0",
                           i, s_wdata, m1_wack, m1_wlast, m0_wack, m0_wlast, w, (i == 7));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({m1_wack, m1_wlast} !== 2'b00) begin
      errors++; $display("FAIL wr_back_idle: got %b expected 00", {m1_wack, m1_wlast});
    end
    clear_inputs();
  endtask

  task automatic test_stall;
    @(negedge clk);
    m0_addr = 32'h300; m0_len = 7'd0; m0_rw = 1'b1; m0_valid = 1'b1; s_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({s_valid, s_addr, m0_ready} !== {1'b1, 32'h300, 1'b0}) begin
        errors++; $display("FAIL stall_hold%0d: got v=%b a=%h r=%b expected v=1 a=300 r=0", k, s_valid, s_addr, m0_ready);
      end
    end
    @(negedge clk);
    s_ready = 1'b1;
    #1;
    checks++;
    if (m0_ready !== 1'b1) begin errors++; $display("FAIL stall_accept: got %b expected 1", m0_ready); end
    @(negedge clk);
    s_ready = 1'b0; m0_valid = 1'b0; s_rstb = 1'b1; s_rlast = 1'b1;
    #1;
    checks++;
    if ({m0_ready, m0_rstb} !== 2'b01) begin
      errors++; $display("FAIL stall_after: got ready/rstb=%b expected 01", {m0_ready, m0_rstb});
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_grant_order;
    int g[$];
    int exp_o[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int cyc;
    @(negedge clk);
    ctrl_all_high();
    m0_rw = 1'b1; m1_rw = 1'b1; m0_valid = 1'b1; m1_valid = 1'b1;
    cyc = 0;
    while (g.size() < 10 && cyc < 100) begin
      #1;
      if (m0_ready) g.push_back(0);
      if (m1_ready) g.push_back(1);
      @(negedge clk);
      cyc++;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    repeat (3) @(negedge clk);
    clear_inputs();
    @(negedge clk);
    checks++;
    if (g.size() < 10) begin
      errors++; $display("FAIL grant_timeout: got %0d grants expected 10", g.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (g[i] !== exp_o[i]) begin
          errors++; $display("FAIL grant_order%0d: got master %0d expected master %0d", i, g[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_strict;
    int n0, n1, cyc;
    @(negedge clk);
    ctrl_all_high();
    m0_rw = 1'b1; m1_rw = 1'b1; m0_valid = 1'b1; m1_valid = 1'b1;
    n0 = 0; n1 = 0; cyc = 0;
    while (n0 < 20 && cyc < 200) begin
      #1;
      if (d0_m0_ready) n0++;
      if (d0_m1_ready) n1++;
      @(negedge clk);
      cyc++;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    repeat (3) @(negedge clk);
    clear_inputs();
    @(negedge clk);
    checks++;
    if (n0 !== 20) begin errors++; $display("FAIL strict_m0_count: got %0d expected 20", n0); end
    checks++;
    if (n1 !== 0) begin errors++; $display("FAIL strict_m1_count: got %0d expected 0", n1); end
  endtask

  task automatic test_reset_mid_burst;
    logic [10:0] outs;
    @(negedge clk);
    m0_addr = 32'h400; m0_len = 7'd7; m0_rw = 1'b1; m0_valid = 1'b1; s_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (s_valid !== 1'b1) begin errors++; $display("FAIL rst_burst_cmd: got %b expected 1", s_valid); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      m0_valid = 1'b0; s_ready = 1'b0; s_rstb = 1'b1; s_rdata = 32'h11 * (i + 1); s_rlast = 1'b0;
      #1;
      checks++;
      if (m0_rstb !== 1'b1) begin errors++; $display("FAIL rst_burst_beat%0d: got %b expected 1", i, m0_rstb); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; s_ready = 1'b1;
    #1;
    outs = {s_valid, m0_ready, m1_ready, m0_wack, m0_wlast, m0_rstb, m0_rlast,
            m1_wack, m1_wlast, m1_rstb, m1_rlast};
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL rst_burst_abandon: got %b expected %b", outs, 11'd0); end
    @(negedge clk);
    s_rstb = 1'b0;
    m1_addr = 32'h500; m1_len = 7'd1; m1_rw = 1'b1; m1_valid = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({s_valid, s_addr, m1_ready, m0_ready} !== {1'b1, 32'h500, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rst_m1_cmd: got v=%b a=%h r1=%b r0=%b expected v=1 a=500 r1=1 r0=0", s_valid, s_addr, m1_ready, m0_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      m1_valid = 1'b0; s_ready = 1'b0; s_rstb = 1'b1; s_rdata = 32'h33 + i; s_rlast = (i == 1);
      #1;
      checks++;
      if ({m1_rstb, m1_rlast, m0_rstb, m1_rdata} !== {1'b1, (i == 1), 1'b0, 32'h33 + i}) begin
        errors++; $display("FAIL rst_m1_beat%0d: got s1=%b l1=%b s0=%b d=%h expected s1=1 l1=%b s0=0 d=%h",
                           i, m1_rstb, m1_rlast, m0_rstb, m1_rdata, (i == 1), 32'h33 + i);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({m1_rstb, s_valid} !== 2'b00) begin errors++; $display("FAIL rst_m1_idle: got %b expected 00", {m1_rstb, s_valid}); end
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_m1();
    test_stall();
    test_grant_order();
    test_strict();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
